// File: rtl/ready_sampler.sv
// ready_sampler: latches per-player ready pulses and, once every player has
// joined, captures a free-running modulo-MOD tick counter as the round number.
// An optional timeout abandons a round that only some players have joined.
module ready_sampler #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned DIV     = 50_000_000,
    parameter int unsigned MOD     = 10,
    parameter int unsigned W       = 4,
    parameter int unsigned TMO     = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [PLAYERS-1:0] READY,
    input  logic               CLR,
    output logic [W-1:0]       NUM,
    output logic               OK,
    output logic [PLAYERS-1:0] LATCHED,
    output logic               TIMEOUT
);

    localparam int unsigned CntW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TcntW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    localparam logic [CntW-1:0]  CntMax = CntW'(DIV - 1);
    localparam logic [W-1:0]     SecMax = W'(MOD - 1);
    localparam logic [TcntW-1:0] TmoVal = TcntW'(TMO);

    typedef enum logic {StCollect, StHold} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]       sec_q, sec_d;
    logic [TcntW-1:0]   tcnt_q, tcnt_d;
    logic [W-1:0]       num_q, num_d;
    logic               ok_q, ok_d;
    logic               timeout_q, timeout_d;
    logic [PLAYERS-1:0] latched_q, latched_d;

    logic tick;
    logic all_ones;
    logic partial;

    assign tick     = (cnt_q == CntMax);
    assign all_ones = &latched_q;
    assign partial  = |latched_q && !all_ones;

    // Free-running prescaler and modulo-MOD tick counter, independent of the FSM.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
        sec_d = sec_q;
        if (tick) begin
            sec_d = (sec_q == SecMax) ? '0 : sec_q + W'(1);
        end
    end

    // Round FSM: collect readies, capture on full set, hold until cleared.
    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        tcnt_d    = tcnt_q;
        num_d     = num_q;
        ok_d      = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (CLR) begin
                    // Clear wins over a same-cycle READY.
                    latched_d = '0;
                    tcnt_d    = '0;
                end else if (all_ones) begin
                    // sec_q is the pre-increment value on this edge.
                    num_d   = sec_q;
                    ok_d    = 1'b1;
                    tcnt_d  = '0;
                    state_d = StHold;
                end else if (TMO > 0 && partial && tick && tcnt_q == TmoVal) begin
                    // A press in the expiry cycle seeds the next round.
                    latched_d = READY;
                    tcnt_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    latched_d = latched_q | READY;
                    if (!partial) begin
                        tcnt_d = '0;
                    end else if (TMO > 0 && tick) begin
                        tcnt_d = tcnt_q + TcntW'(1);
                    end
                end
            end
            StHold: begin
                tcnt_d = '0;
                if (CLR) begin
                    latched_d = '0;
                    state_d   = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StCollect;
            cnt_q     <= '0;
            sec_q     <= '0;
            tcnt_q    <= '0;
            num_q     <= '0;
            ok_q      <= 1'b0;
            timeout_q <= 1'b0;
            latched_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sec_q     <= sec_d;
            tcnt_q    <= tcnt_d;
            num_q     <= num_d;
            ok_q      <= ok_d;
            timeout_q <= timeout_d;
            latched_q <= latched_d;
        end
    end

    assign NUM     = num_q;
    assign OK      = ok_q;
    assign LATCHED = latched_q;
    assign TIMEOUT = timeout_q;

endmodule
